ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameters: none. Geometry is fixed at 32 words x 8 bits, 5-bit address.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 reqN_valid  in  1  requester N (N=0,1) command valid.
REQ-005 reqN_ready  out  1  command from requester N accepted this cycle.
REQ-006 reqN_we  in  1  1 = write, 0 = read.
REQ-007 reqN_addr  in  5  word address.
REQ-008 reqN_wdata  in  8  write data.
REQ-009 rspN_valid  out  1  one-cycle completion pulse to requester N.
REQ-010 rspN_rdata  out  8  read data; 0 for writes and whenever rspN_valid=0.
REQ-011 ram_din  out  8  to RAM data input.
REQ-012 ram_addr  out  5  to RAM address.
REQ-013 ram_w_en  out  1  to RAM write enable.
REQ-014 ram_dout  in  8  from RAM registered output; valid the cycle after the RAM edge that performed the read.

Function
REQ-015 Accept: the command on reqN is accepted at a rising edge where reqN_valid=1 and reqN_ready=1; at most one command is accepted per cycle.
REQ-016 Arbitration: reqN_ready = rst_n & reqN_valid & grantN; grantN is combinational from both valids and last_grant. reqN_ready may depend combinationally on reqN_valid.
REQ-017 Round-robin: if only one port is valid, that port wins. If both are valid, the port not equal to last_grant wins. last_grant updates to the winner on every accept.
REQ-018 No backpressure on responses: a valid requester is refused only by arbitration loss or reset.
REQ-019 Stage 1 (S1) registers are loaded on accept: s1_valid, s1_port, s1_we, s1_addr, s1_wdata. s1_valid=0 on any cycle without an accept.
REQ-020 RAM drive from S1:
  - ram_addr = s1_addr and ram_din = s1_wdata when s1_valid=1; both are 0 otherwise.
  - ram_w_en = rst_n & s1_valid & s1_we.
REQ-021 Stage 2 (S2) registers copy s1_valid, s1_port and s1_we at each edge.
REQ-022 Response:
  - rspN_valid = s2_valid & (s2_port==N).
  - rspN_rdata = ram_dout when that response is a read; 0 otherwise.
REQ-023 Latency: accept at edge E produces the RAM operation at edge E+1 and the response during the cycle after E+1 (two cycles after accept). Full throughput is one command per cycle.
REQ-024 Ordering: responses return in global accept order. A read accepted the cycle after a write to the same address returns the new data, with no stall.
REQ-025 A port whose valid drops before it is accepted is not serviced. Its address and data are don't-care while valid=0.

Reset
REQ-026 With rst_n=0 at an edge, the following clear to 0: s1_valid, s2_valid, all S1/S2 data fields, and last_grant is set to 1.
REQ-027 Outputs while rst_n=0: reqN_ready=0 and ram_w_en=0.
REQ-028 Outputs after the reset edge: rspN_valid=0, rspN_rdata=0, ram_addr=0, ram_din=0.
REQ-029 Commands in flight at the reset edge are dropped and produce no response. A write in S1 during a rst_n=0 cycle does not reach the RAM.
REQ-030 The first contended grant after reset goes to port 0.

Configuration
REQ-031 Macro ARB_FIXED_PRIO_EN defined: port 0 always wins contention. last_grant is still maintained but ignored by the grant logic.
REQ-032 Macro ARB_FIXED_PRIO_EN undefined: round-robin per REQ-017. Interface and latency are identical in both builds.

Verification
REQ-033 Write then read: reset, port0 writes 0xA5 to addr 3 -> read addr 3 on port0 -> rsp0_valid two cycles after each accept; read rdata=0xA5; write rdata=0.
REQ-034 Contention: both ports valid every cycle for 4 cycles from reset -> grants 0,1,0,1. With ARB_FIXED_PRIO_EN -> grants 0,0,0,0 and req1_ready=0 throughout.
REQ-035 Back-to-back RAW: port1 writes 0x3C to addr 31 (cycle T), port1 reads addr 31 (cycle T+1) -> rsp1 at T+2 (write, rdata 0) and T+3 (rdata 0x3C).
REQ-036 Mixed ports: port0 reads addr 7 (pre-written 0x11) while port1 writes 0x22 to addr 7 in the same cycle, round-robin with last_grant=1 -> port0 served first and gets 0x11; port1 accepted next cycle.
REQ-037 Reset mid-operation: accept a write of 0xFF to addr 0, assert rst_n=0 the next cycle -> ram_w_en stays 0, no rsp pulse, and a later read of addr 0 returns the old value.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter in front of a 32x8 single-port RAM with
// a registered read output. Commands are accepted one per cycle, pass through
// a command stage (S1) that drives the RAM, then a response stage (S2) that
// lines up with the RAM read data. Responses return two cycles after accept,
// in global accept order.
//
// Build option:
//   ARB_FIXED_PRIO_EN  defined   -> port 0 always wins contention
//                      undefined -> round-robin on contention (default)
module ram_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    // requester 0
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_we,
    input  logic [4:0] req0_addr,
    input  logic [7:0] req0_wdata,
    output logic       rsp0_valid,
    output logic [7:0] rsp0_rdata,
    // requester 1
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_we,
    input  logic [4:0] req1_addr,
    input  logic [7:0] req1_wdata,
    output logic       rsp1_valid,
    output logic [7:0] rsp1_rdata,
    // RAM side
    output logic [7:0] ram_din,
    output logic [4:0] ram_addr,
    output logic       ram_w_en,
    input  logic [7:0] ram_dout
);

    logic       grant0;
    logic       grant1;
    logic       accept;

    logic       last_grant_q, last_grant_d;
    logic       s1_valid_q,   s1_valid_d;
    logic       s1_port_q,    s1_port_d;
    logic       s1_we_q,      s1_we_d;
    logic [4:0] s1_addr_q,    s1_addr_d;
    logic [7:0] s1_wdata_q,   s1_wdata_d;
    logic       s2_valid_q,   s2_valid_d;
    logic       s2_port_q,    s2_port_d;
    logic       s2_we_q,      s2_we_d;

    // Arbitration: a lone requester always wins; contention is settled by
    // priority mode (last_grant points at the port that won most recently).
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        grant0 = req0_valid;
        grant1 = req1_valid;
        if (req0_valid && req1_valid) begin
`ifdef ARB_FIXED_PRIO_EN
            grant0 = 1'b1;
            grant1 = 1'b0;
`else
            grant0 = last_grant_q;
            grant1 = ~last_grant_q;
`endif
        end
    end

    assign req0_ready = rst_n & req0_valid & grant0;
    assign req1_ready = rst_n & req1_valid & grant1;
    assign accept     = req0_ready | req1_ready;

    // Next-state: load S1 from the winning port, shift S1 into S2.
    always_comb begin
        last_grant_d = last_grant_q;
        s1_valid_d   = accept;
        s1_port_d    = s1_port_q;
        s1_we_d      = s1_we_q;
        s1_addr_d    = s1_addr_q;
        s1_wdata_d   = s1_wdata_q;
        s2_valid_d   = s1_valid_q;
        s2_port_d    = s1_port_q;
        s2_we_d      = s1_we_q;
        if (accept) begin
            last_grant_d = req1_ready;
            s1_port_d    = req1_ready;
            s1_we_d      = req1_ready ? req1_we    : req0_we;
            s1_addr_d    = req1_ready ? req1_addr  : req0_addr;
            s1_wdata_d   = req1_ready ? req1_wdata : req0_wdata;
        end
    end

    // Pipeline and arbitration state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            s1_valid_q   <= 1'b0;
            s1_port_q    <= 1'b0;
            s1_we_q      <= 1'b0;
            s1_addr_q    <= '0;
            s1_wdata_q   <= '0;
            s2_valid_q   <= 1'b0;
            s2_port_q    <= 1'b0;
            s2_we_q      <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            s1_valid_q   <= s1_valid_d;
            s1_port_q    <= s1_port_d;
            s1_we_q      <= s1_we_d;
            s1_addr_q    <= s1_addr_d;
            s1_wdata_q   <= s1_wdata_d;
            s2_valid_q   <= s2_valid_d;
            s2_port_q    <= s2_port_d;
            s2_we_q      <= s2_we_d;
        end
    end

    // RAM drive from S1; the write enable is also gated by reset so a write
    // caught in S1 during a reset cycle never reaches the array.
    assign ram_addr = s1_valid_q ? s1_addr_q  : 5'd0;
    assign ram_din  = s1_valid_q ? s1_wdata_q : 8'd0;
    assign ram_w_en = rst_n & s1_valid_q & s1_we_q;

    // Responses from S2, aligned with the registered RAM output.
    assign rsp0_valid = s2_valid_q & ~s2_port_q;
    assign rsp1_valid = s2_valid_q &  s2_port_q;
    assign rsp0_rdata = (rsp0_valid && !s2_we_q) ? ram_dout : 8'd0;
    assign rsp1_rdata = (rsp1_valid && !s2_we_q) ? ram_dout : 8'd0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: table-driven bench for ram_arbiter. Each vector sets the
// inputs for one cycle and gives the expected ready bits; a reference S1 stage
// and shadow memory push expected responses into a scoreboard queue, which is
// popped and compared one cycle later. The bench also models the RAM.
// Build with +define+ARB_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_ram_arbiter;

    typedef struct packed {
        logic       rst_n;
        logic       v0;
        logic       we0;
        logic [4:0] a0;
        logic [7:0] d0;
        logic       v1;
        logic       we1;
        logic [4:0] a1;
        logic [7:0] d1;
        logic       r0;
        logic       r1;
    } vec_t;

    typedef struct packed {
        logic       valid;
        logic       port;
        logic       we;
        logic [4:0] addr;
        logic [7:0] data;
    } s1m_t;

    typedef struct packed {
        logic       port;
        logic [7:0] rdata;
    } sb_t;

`ifdef ARB_FIXED_PRIO_EN
    localparam logic [3:0] CONT_R0 = 4'b1111;
    localparam logic [3:0] CONT_R1 = 4'b0000;
    localparam logic       LOSE_R0 = 1'b1;
    localparam logic       LOSE_R1 = 1'b0;
`else
    localparam logic [3:0] CONT_R0 = 4'b0101;  // bit i = cycle i
    localparam logic [3:0] CONT_R1 = 4'b1010;
    localparam logic       LOSE_R0 = 1'b0;
    localparam logic       LOSE_R1 = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_we;
    logic [4:0] req0_addr;
    logic [7:0] req0_wdata;
    logic       rsp0_valid;
    logic [7:0] rsp0_rdata;
    logic       req1_valid, req1_ready, req1_we;
    logic [4:0] req1_addr;
    logic [7:0] req1_wdata;
    logic       rsp1_valid;
    logic [7:0] rsp1_rdata;
    logic [7:0] ram_din;
    logic [4:0] ram_addr;
    logic       ram_w_en;
    logic [7:0] ram_dout;

    logic       tb_init = 1'b1;
    logic [7:0] mem     [32];
    logic [7:0] ref_mem [32];
    s1m_t       m_s1;
    sb_t        sb [$];
    vec_t       vecs [$];
    int         n_checks = 0;
    int         n_errors = 0;

    ram_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .ram_din    (ram_din),
        .ram_addr   (ram_addr),
        .ram_w_en   (ram_w_en),
        .ram_dout   (ram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 3 + 1);
    endfunction

    // RAM model: registered read output, preloaded on the first edge.
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= pat(i);
        end else if (ram_w_en) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic v0, input logic we0,
                                input logic [4:0] a0, input logic [7:0] d0,
                                input logic v1, input logic we1,
                                input logic [4:0] a1, input logic [7:0] d1,
                                input logic r0, input logic r1);
        vec_t v;
        v.rst_n = rst; v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    // One cycle: drive, compare at negedge, advance the reference at posedge.
    task automatic step(input vec_t v);
        sb_t        e;
        logic       e_v0, e_v1;
        logic [7:0] e_d0, e_d1;
        rst_n      = v.rst_n;
        req0_valid = v.v0; req0_we = v.we0; req0_addr = v.a0; req0_wdata = v.d0;
        req1_valid = v.v1; req1_we = v.we1; req1_addr = v.a1; req1_wdata = v.d1;
        @(negedge clk);
        check("req0_ready", req0_ready, v.r0);
        check("req1_ready", req1_ready, v.r1);
        e_v0 = 1'b0; e_v1 = 1'b0; e_d0 = 8'd0; e_d1 = 8'd0;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.port) begin e_v1 = 1'b1; e_d1 = e.rdata; end
            else        begin e_v0 = 1'b1; e_d0 = e.rdata; end
        end
        check("rsp0_valid", rsp0_valid, e_v0);
        check("rsp0_rdata", rsp0_rdata, e_d0);
        check("rsp1_valid", rsp1_valid, e_v1);
        check("rsp1_rdata", rsp1_rdata, e_d1);
        check("ram_w_en", ram_w_en, v.rst_n & m_s1.valid & m_s1.we);
        check("ram_addr", ram_addr, m_s1.valid ? m_s1.addr : 5'd0);
        check("ram_din",  ram_din,  m_s1.valid ? m_s1.data : 8'd0);
        if (v.rst_n && m_s1.valid) begin
            e.port = m_s1.port;
            if (m_s1.we) begin
                ref_mem[m_s1.addr] = m_s1.data;
                e.rdata = 8'd0;
            end else begin
                e.rdata = ref_mem[m_s1.addr];
            end
            sb.push_back(e);
        end
        @(posedge clk);
        m_s1 = '0;
        if (!v.rst_n) begin
            sb.delete();
        end else if (v.r0) begin
            m_s1.valid = 1'b1; m_s1.port = 1'b0; m_s1.we = v.we0;
            m_s1.addr = v.a0; m_s1.data = v.d0;
        end else if (v.r1) begin
            m_s1.valid = 1'b1; m_s1.port = 1'b1; m_s1.we = v.we1;
            m_s1.addr = v.a1; m_s1.data = v.d1;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = pat(i);
        m_s1 = '0;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
        @(posedge clk);
        #1;
        tb_init = 1'b0;

        // reset, with requests present: nothing may be accepted
        vecs.push_back(mk(0, 0,0,5'd0,8'h00,   0,0,5'd0,8'h00,  0,0));
        vecs.push_back(mk(0, 1,1,5'd3,8'hA5,   1,1,5'd4,8'h5A,  0,0));
        // write then read on port 0
        vecs.push_back(mk(1, 1,1,5'd3,8'hA5,   0,0,5'd0,8'h00,  1,0));
        vecs.push_back(mk(1, 1,0,5'd3,8'h00,   0,0,5'd0,8'h00,  1,0));
        vecs.push_back(mk(1, 0,0,5'd0,8'h00,   0,0,5'd0,8'h00,  0,0));
        vecs.push_back(mk(1, 0,0,5'd0,8'h00,   0,0,5'd0,8'h00,  0,0));
        // back-to-back write/read of addr 31 on port 1
        vecs.push_back(mk(1, 0,0,5'd0,8'h00,   1,1,5'd31,8'h3C, 0,1));
        vecs.push_back(mk(1, 0,0,5'd0,8'h00,   1,0,5'd31,8'h00, 0,1));
        // pre-write addr 7 with 0x11
        vecs.push_back(mk(1, 0,0,5'd0,8'h00,   1,1,5'd7,8'h11,  0,1));
        vecs.push_back(mk(1, 0,0,5'd0,8'h00,   0,0,5'd0,8'h00,  0,0));
        vecs.push_back(mk(1, 0,0,5'd0,8'h00,   0,0,5'd0,8'h00,  0,0));
        // reset, then four contended cycles
        vecs.push_back(mk(0, 0,0,5'd0,8'h00,   0,0,5'd0,8'h00,  0,0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 1,0,5'd1,8'h00, 1,0,5'd2,8'h00, CONT_R0[i], CONT_R1[i]));
        // mixed ports on addr 7: port 0 reads old data, port 1 writes next
        vecs.push_back(mk(1, 1,0,5'd7,8'h00,   1,1,5'd7,8'h22,  1,0));
        vecs.push_back(mk(1, 0,0,5'd0,8'h00,   1,1,5'd7,8'h22,  0,1));
        vecs.push_back(mk(1, 1,0,5'd7,8'h00,   0,0,5'd0,8'h00,  1,0));
        // contention after a port-0 win; the loser then withdraws
        vecs.push_back(mk(1, 1,0,5'd2,8'h00,   1,0,5'd4,8'h00,  LOSE_R0,LOSE_R1));
        vecs.push_back(mk(1, 0,0,5'd0,8'h00,   0,0,5'd0,8'h00,  0,0));
        // full throughput, alternating ports
        vecs.push_back(mk(1, 1,1,5'd10,8'h5A,  0,0,5'd0,8'h00,  1,0));
        vecs.push_back(mk(1, 0,0,5'd0,8'h00,   1,1,5'd11,8'h6B, 0,1));
        vecs.push_back(mk(1, 1,0,5'd10,8'h00,  0,0,5'd0,8'h00,  1,0));
        vecs.push_back(mk(1, 0,0,5'd0,8'h00,   1,0,5'd11,8'h00, 0,1));
        vecs.push_back(mk(1, 0,0,5'd0,8'h00,   0,0,5'd0,8'h00,  0,0));
        vecs.push_back(mk(1, 0,0,5'd0,8'h00,   0,0,5'd0,8'h00,  0,0));

        foreach (vecs[i]) step(vecs[i]);

        // reset arriving while a write sits in S1: write and response dropped
        step(mk(1, 1,1,5'd0,8'hFF, 0,0,5'd0,8'h00, 1,0));
        step(mk(0, 0,0,5'd0,8'h00, 0,0,5'd0,8'h00, 0,0));
        check("rst_drop_queue", sb.size(), 0);
        step(mk(1, 0,0,5'd0,8'h00, 0,0,5'd0,8'h00, 0,0));
        check("rst_no_rsp0", rsp0_valid, 1'b0);
        step(mk(1, 1,0,5'd0,8'h00, 0,0,5'd0,8'h00, 1,0));
        step(mk(1, 0,0,5'd0,8'h00, 0,0,5'd0,8'h00, 0,0));
        step(mk(1, 0,0,5'd0,8'h00, 0,0,5'd0,8'h00, 0,0));

        // final state of the modelled RAM array
        check("mem0_kept",  mem[0],  pat(0));
        check("mem31_raw",  mem[31], 8'h3C);
        check("mem7_final", mem[7],  8'h22);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
